adder_result_fifo: RTL and testbench

//  Downstream companion to the fully pipelined adder: tracks which issued operand pairs are in flight,

---
 rtl/adder_result_fifo_if.sv | 26 ++
 rtl/adder_result_fifo.sv | 123 ++++++++++++
 tb/tb_adder_result_fifo.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_result_fifo_if.sv
// Handshake bundle between the operand driver / adder outputs and the
// result FIFO. The master side issues operands, supplies the adder outputs
// and consumes results. The slave side is the result FIFO.
interface adder_result_fifo_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             ovf_err;

  modport master (
    output in_valid, add_s, add_c, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, ovf_err
  );

  modport slave (
    input  in_valid, add_s, add_c, out_ready,
    output in_ready, out_valid, out_sum, out_carry, ovf_err
  );
endinterface

// File: rtl/adder_result_fifo.sv
// Result tracker and buffer for a fully pipelined WIDTH-cycle adder.
// A valid shift register follows each issued operand pair through the
// adder. When the pair emerges, {carry,sum} is written into a DEPTH-entry
// show-ahead FIFO. Issue is credit-limited so that every result in flight
// already owns a FIFO slot, so backpressure never drops a result.
module adder_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_result_fifo_if.slave bus_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(WIDTH + 1);
  localparam int CRD_W = $clog2(DEPTH + WIDTH + 1) + 1;

  // Carry in the MSB, sum below it.
  typedef logic [WIDTH:0] entry_t;

  logic [WIDTH-1:0] vld_sr_q,   vld_sr_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             ovf_err_q,  ovf_err_d;
  entry_t           mem_q [DEPTH];

  logic   issue;
  logic   arrive;
  logic   pop;
  logic   full;
  logic   wr_en;
  entry_t head;

  assign issue  = bus_if.in_valid & bus_if.in_ready;
  assign arrive = vld_sr_q[WIDTH-1];
  assign pop    = bus_if.out_valid & bus_if.out_ready;
  assign full   = (count_q == CNT_W'(DEPTH));
  // A full FIFO still accepts a result if the head leaves in the same cycle.
  assign wr_en  = arrive & (~full | pop);

  // Credit check uses registered state only, so in_ready never depends on in_valid.
  assign bus_if.in_ready = (CRD_W'(count_q) + CRD_W'(inflight_q)) < CRD_W'(DEPTH);

  assign head             = mem_q[rd_ptr_q];
  assign bus_if.out_valid = (count_q != '0);
  assign bus_if.out_sum   = bus_if.out_valid ? head[WIDTH-1:0] : '0;
  assign bus_if.out_carry = bus_if.out_valid ? head[WIDTH]     : 1'b0;
  assign bus_if.ovf_err   = ovf_err_q;

  // Next-state computation for tracking, pointers, occupancy and error flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    vld_sr_d   = '0;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_err_d  = ovf_err_q;

    vld_sr_d[0] = issue;
    for (int i = 1; i < WIDTH; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end

    // Decrement guarded so a spurious arrival cannot wrap the counter.
    if (issue && !arrive) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!issue && arrive && (inflight_q != '0)) begin
      inflight_d = inflight_q - INF_W'(1);
    end

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    // A result arriving at a full FIFO with no pop is dropped and flagged.
    if (arrive && full && !pop) begin
      ovf_err_d = 1'b1;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q   <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      vld_sr_q   <= vld_sr_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  // Result storage, written at wr_ptr when a tracked result arrives.
  // NOTE: storage has no reset. Entries are only visible while counted, and the outputs are gated to 0 when empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {bus_if.add_c, bus_if.add_s};
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo. It contains a behavioural pipelined adder
// feeding add_s/add_c, and a scoreboard queue that is pushed on every issue
// and popped on every accepted result.
module tb_adder_result_fifo;
  localparam int W = 4;
  localparam int D = 4;
  localparam logic [W-1:0] ARRIVE_ONLY = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_result_fifo_if #(.WIDTH(W)) bus_if ();

  adder_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  // Operands presented to the adder alongside in_valid.
  logic [W-1:0] op_a, op_b;
  logic         op_cin;

  // Pipelined adder model with WIDTH cycles of latency and no reset.
  logic [W:0] pipe [W];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + (W+1)'(op_cin);
    for (int i = 1; i < W; i++) pipe[i] <= pipe[i-1];
  end
  assign bus_if.add_s = pipe[W-1][W-1:0];
  assign bus_if.add_c = pipe[W-1][W];

  int         n_checks = 0;
  int         n_errs   = 0;
  int         pops     = 0;
  int         n_iss    = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard at the falling edge, where all handshake signals are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.out_valid && bus_if.out_ready) begin
        pops++;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("sb_result", {bus_if.out_carry, bus_if.out_sum}, exp_q.pop_front());
        end
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + (W+1)'(op_cin));
      end
    end
  end

  // One cycle of random operands with the given valid/ready, then count an issue.
  task automatic issue_cycle(input logic v, input logic r);
    @(posedge clk); #1;
    bus_if.in_valid  = v;
    bus_if.out_ready = r;
    op_a   = W'($urandom);
    op_b   = W'($urandom);
    op_cin = 1'($urandom);
    @(negedge clk);
    if (v && bus_if.in_ready) n_iss++;
  endtask

  task automatic idle_cycles(input int n, input logic r);
    for (int i = 0; i < n; i++) issue_cycle(1'b0, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   t;
    logic seen;
    logic [W:0] head_exp;

    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_in_ready",  bus_if.in_ready,  1);
    check("rst_out_sum",   bus_if.out_sum,   0);
    check("rst_out_carry", bus_if.out_carry, 0);
    check("rst_ovf_err",   bus_if.ovf_err,   0);

    // T1: single issue 3+5, exact latency.
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1; op_a = 4'd3; op_b = 4'd5; op_cin = 1'b0;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t1_out_valid", bus_if.out_valid, 32'(k == 5));
    end
    check("t1_out_sum",   bus_if.out_sum,   8);
    check("t1_out_carry", bus_if.out_carry, 0);
    idle_cycles(2, 1'b0);
    check("t1_hold_valid", bus_if.out_valid, 1);
    check("t1_hold_sum",   bus_if.out_sum,   8);
    idle_cycles(3, 1'b1);
    check("t1_drained", 32'(exp_q.size()), 0);

    // T2: back-to-back issues with no output bubbles.
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid = 1'b1; op_a = 4'd15; op_b = 4'd1; op_cin = 1'b0;
    @(posedge clk); #1;
    op_a = 4'd7; op_b = 4'd7; op_cin = 1'b1;
    @(posedge clk); #1;
    op_a = 4'd0; op_b = 4'd0; op_cin = 1'b0;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus_if.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t2_first_valid", bus_if.out_valid, 1);
    @(negedge clk);
    check("t2_second_valid", bus_if.out_valid, 1);
    @(negedge clk);
    check("t2_third_valid", bus_if.out_valid, 1);
    @(negedge clk);
    check("t2_after_valid", bus_if.out_valid, 0);
    check("t2_drained", 32'(exp_q.size()), 0);

    // T3: credit limit under full backpressure.
    n_iss = 0;
    for (int i = 0; i < 12; i++) issue_cycle(1'b1, 1'b0);
    idle_cycles(6, 1'b0);
    check("t3_issues",   n_iss, D);
    check("t3_in_ready", bus_if.in_ready, 0);
    check("t3_count",    dut.count_q, D);
    check("t3_ovf",      bus_if.ovf_err, 0);
    check("t3_sb_level", 32'(exp_q.size()), D);
    idle_cycles(8, 1'b1);
    check("t3_drained",      32'(exp_q.size()), 0);
    check("t3_in_ready_back", bus_if.in_ready, 1);
    check("t3_empty",        bus_if.out_valid, 0);

    // T4: full FIFO, pop frees a credit, then wrap-around over 10 results.
    n_iss = 0;
    base  = pops;
    for (int i = 0; i < 8; i++) issue_cycle(1'b1, 1'b0);
    idle_cycles(6, 1'b0);
    check("t4_full_count", dut.count_q, D);
    issue_cycle(1'b1, 1'b1);
    check("t4_full_no_ready", bus_if.in_ready, 0);
    issue_cycle(1'b1, 1'b0);
    check("t4_credit_back", bus_if.in_ready, 1);
    t = 0;
    while (n_iss < 10 && t < 400) begin
      issue_cycle(1'b1, 1'($urandom));
      t++;
    end
    idle_cycles(12, 1'b1);
    check("t4_issues",  n_iss, 10);
    check("t4_pops",    pops - base, 10);
    check("t4_drained", 32'(exp_q.size()), 0);

    // T5: reset while operations are in flight.
    issue_cycle(1'b1, 1'b1);
    issue_cycle(1'b1, 1'b1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus_if.out_valid;
    end
    check("t5_no_stale",  seen, 0);
    check("t5_in_ready",  bus_if.in_ready, 1);
    check("t5_count",     dut.count_q, 0);

    // T6: forced arrival at a full FIFO sets the sticky overflow flag.
    for (int i = 0; i < D; i++) issue_cycle(1'b1, 1'b0);
    idle_cycles(6, 1'b0);
    check("t6_full", dut.count_q, D);
    head_exp = exp_q[0];
    @(posedge clk); #1;
    force dut.vld_sr_q = ARRIVE_ONLY;
    @(posedge clk); #1;
    release dut.vld_sr_q;
    @(negedge clk);
    check("t6_ovf_set",   bus_if.ovf_err, 1);
    check("t6_count",     dut.count_q, D);
    check("t6_head",      {bus_if.out_carry, bus_if.out_sum}, head_exp);
    idle_cycles(3, 1'b0);
    check("t6_ovf_sticky", bus_if.ovf_err, 1);
    idle_cycles(8, 1'b1);
    check("t6_drained",    32'(exp_q.size()), 0);
    check("t6_empty",      bus_if.out_valid, 0);
    check("t6_ovf_still",  bus_if.ovf_err, 1);

    // Reset clears the flag.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("final_ovf_clear", bus_if.ovf_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
